progmem_port_arbiter: RTL and testbench
=======================================

// Module: progmem_port_arbiter
// PURPOSE
//  Shares port B of the dual-port program memory between two requesters:
//  M0 (core data bus) and M1 (debug/boot loader). Each cycle it grants at most one
//  single-word access, using round-robin priority. M1 may hold a bounded lock for
//  burst loads. Returns read data one cycle after grant, tagged to the owner.
// PARAMETERS
//  AW        14   word address width (matches memory depth 2**AW)
//  DW        32   data width
//  MAX_LOCK  16   max consecutive M1 grants under lock while M0 waits (>=1)
// PORTS
//  clk        in   1    single clock, all state on posedge
//  rstn       in   1    asynchronous active-low reset
//  m0_req     in   1    M0 access request, held until m0_gnt
//  m0_we      in   1    M0 write (1) / read (0)
//  m0_addr    in   AW   M0 word address
//  m0_wdata   in   DW   M0 write data
//  m0_gnt     out  1    M0 access accepted this cycle (combinational)
//  m0_rvalid  out  1    M0 read data valid (registered)
//  m0_rdata   out  DW   M0 read data, meaningful only when m0_rvalid
//  m1_req/m1_we/m1_addr/m1_wdata/m1_gnt/m1_rvalid/m1_rdata   as M0, for M1
//  m1_lock    in   1    M1 requests priority retention between accesses
//  mem_en     out  4    port-B enable, all bits = granted access (4'hF or 4'h0)
//  mem_we     out  1    port-B write enable
//  mem_addr   out  AW   port-B address
//  mem_din    out  DW   port-B write data
//  mem_dout   in   DW   port-B read data (memory registers address on clk)
// BEHAVIOUR
//  - State: last (1b, last granted master), rv0/rv1 (rvalid regs), lock_cnt.
//  - Reset (rstn=0, async): last=1, rv0=rv1=0, lock_cnt=0. m0/m1_rvalid=0.
//    Gnt and mem_* are combinational; with no req, mem_en=0, mem_we=0.
//  - Grant, same cycle as req:
//    - only one master requesting -> it is granted.
//    - both requesting -> priority to the master != last.
//    - Lock exception: if last=1, m1_lock=1 and lock_cnt<MAX_LOCK, M1 wins.
//  - Grant drives mem_en=4'hF, mem_we/addr/din from the winner. Loser sees gnt=0,
//    must hold its request stable. At most one gnt high per cycle.
//  - last updates to the winner on every grant; unchanged in idle cycles.
//  - lock_cnt: +1 when M1 granted while m0_req=1 and lock honoured.
//    Cleared when M0 is granted or m1_lock=0. Saturates at MAX_LOCK;
//    MAX_LOCK forces the next contested grant to M0.
//  - Read latency 1: granted read in cycle N -> rvX=1 in N+1 with
//    rdata=mem_dout. Writes never raise rvalid. Both rdata ports tie to mem_dout.
//  - Back-to-back: reads may issue every cycle. rvalid of N+1 and gnt of N+1
//    are independent; no bubble.
//  - Write then read same address on consecutive cycles returns new data.
//  - Reset mid-read: pending rvalid dropped, no response issued after rstn rises.
//  - Requests with X-free we/addr only; req must not drop before gnt (protocol).
// TESTING
//  1 Reset: rstn=0 with m0_req=m1_req=1 mid-cycle -> rvalids 0 immediately;
//    after release, first contested grant goes to M0 (last=1).
//  2 Single read: M0 read addr 0x0010 (mem=0xDEADBEEF) -> m0_gnt same cycle,
//    next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
//  3 Round-robin: both masters request reads every cycle for 6 cycles, no lock ->
//    grants alternate M0,M1,M0,M1,M0,M1; each rvalid lands on the correct master.
//  4 Lock bound: MAX_LOCK=4, m1_lock=1, both stream writes -> M1 granted 1+4 times
//    then M0 granted once; lock_cnt clears; m1_lock=0 -> strict alternation.
//  5 RAW: M1 writes 0x12345678 to 0x3FFF, next cycle M0 reads 0x3FFF ->
//    m0_rdata=0x12345678; no rvalid ever raised for the write.
//  6 Idle/reset mid-op: grant M0 read, assert rstn=0 before next edge ->
//    m0_rvalid stays 0; mem_en=0 whenever both req=0.

Source files
------------

// File: rtl/progmem_port_arbiter_if.sv
// Bus bundle for the program-memory port-B arbiter.
// Carries both requester ports (M0 core data bus, M1 debug/boot loader) and the
// memory-side port-B signals.
//   slave  : arbiter view (requests in, grants/read data/memory controls out)
//   master : environment view (requesters and memory model)
interface progmem_port_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic [3:0]    mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/progmem_port_arbiter.sv
// Round-robin arbiter sharing port B of the dual-port program memory between
// M0 (core data bus) and M1 (debug/boot loader). At most one single-word access
// is granted per cycle; M1 may hold priority for a bounded run of accesses via
// m1_lock. Read data returns one cycle after the grant, tagged to its owner.
// Ports:
//   clk   in  clock, all state on posedge
//   rstn  in  asynchronous active-low reset
//   bus   slave modport of progmem_port_arbiter_if (requesters + port B)
module progmem_port_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    progmem_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic          last_q, last_d;
    logic          rv0_q, rv0_d;
    logic          rv1_q, rv1_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;

    logic          both_req;
    logic          lock_hon;
    logic          gnt0;
    logic          gnt1;
    logic          we_mux;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] din_mux;

    always_comb begin
        both_req = bus.m0_req & bus.m1_req;
        // Lock only matters when M1 would otherwise lose its turn.
        lock_hon = both_req & last_q & bus.m1_lock & (lock_cnt_q < CW'(MAX_LOCK));

        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (both_req) begin
            if (lock_hon) begin
                gnt1 = 1'b1;
            end else if (last_q) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = bus.m0_req;
            gnt1 = bus.m1_req;
        end

        we_mux   = gnt1 ? bus.m1_we    : (gnt0 & bus.m0_we);
        addr_mux = gnt1 ? bus.m1_addr  : bus.m0_addr;
        din_mux  = gnt1 ? bus.m1_wdata : bus.m0_wdata;

        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end

        rv0_d = gnt0 & ~bus.m0_we;
        rv1_d = gnt1 & ~bus.m1_we;

        // Count only grants won through the lock; an M0 grant or a dropped
        // lock restarts the budget. The < compare in lock_hon saturates it.
        lock_cnt_d = lock_cnt_q;
        if (gnt0 || !bus.m1_lock) begin
            lock_cnt_d = '0;
        end else if (lock_hon) begin
            lock_cnt_d = lock_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q     <= 1'b1;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            rv0_q      <= rv0_d;
            rv1_q      <= rv1_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rv0_q;
    assign bus.m1_rvalid = rv1_q;
    assign bus.m0_rdata  = bus.mem_dout;
    assign bus.m1_rdata  = bus.mem_dout;
    assign bus.mem_en    = {4{gnt0 | gnt1}};
    assign bus.mem_we    = we_mux;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_din   = din_mux;
endmodule

// File: tb/tb_progmem_port_arbiter.sv
// Scoreboard bench for progmem_port_arbiter (MAX_LOCK=4). The driver pushes the
// expected grant/port-B controls and expected read responses into queues; a
// monitor on the falling edge pops and compares whatever the DUT presents.
module tb_progmem_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;

    typedef struct {
        logic [1:0]    gnt;   // {m1_gnt, m0_gnt}
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } gexp_t;

    typedef struct {
        logic [1:0]    who;   // {m1_rvalid, m0_rvalid}
        logic [DW-1:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    progmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    progmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    gexp_t gq[$];
    rexp_t rq[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Background contents for any word never written.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 14'h0010) ? 32'hDEADBEEF : {18'h2A5A5, a};
    endfunction

    // Memory model: registers address on clk, read data valid next cycle.
    logic [DW-1:0] mem [logic [AW-1:0]];
    always @(posedge clk) begin
        if (bus.mem_en == 4'hF) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] = bus.mem_din;
            end else begin
                bus.mem_dout <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : init_val(bus.mem_addr);
            end
        end
    end

    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; eg = expected grant (0 none, 1 M0, 2 M1).
    task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic l1, input logic [1:0] eg);
        gexp_t g;
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
        bus.m1_lock = l1;
        if (r0 || r1) begin
            g.gnt = eg;
            g.we = (eg == 2'd1) ? w0 : w1;
            g.addr = (eg == 2'd1) ? a0 : a1;
            g.din = (eg == 2'd1) ? d0 : d1;
            gq.push_back(g);
        end
        if (eg == 2'd1) begin
            if (w0) ref_mem[a0] = d0;
            else rq.push_back('{2'b01, ref_rd(a0)});
        end else if (eg == 2'd2) begin
            if (w1) ref_mem[a1] = d1;
            else rq.push_back('{2'b10, ref_rd(a1)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
    endtask

    // Monitor: grant/port-B controls and read responses.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (bus.m0_req || bus.m1_req) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected_req", 64'(gq.size()), 64'd1);
                end else begin
                    gexp_t g;
                    g = gq.pop_front();
                    chk("gnt", {62'd0, bus.m1_gnt, bus.m0_gnt}, {62'd0, g.gnt});
                    chk("mem_en", {60'd0, bus.mem_en}, (g.gnt != 2'd0) ? 64'hF : 64'h0);
                    chk("mem_ctl", {bus.mem_we, 5'd0, bus.mem_addr, 12'd0, bus.mem_din},
                        {g.we, 5'd0, g.addr, 12'd0, g.din});
                end
            end else begin
                chk("idle_en_gnt", {58'd0, bus.mem_en, bus.m1_gnt, bus.m0_gnt}, 64'd0);
            end
            if (bus.m0_rvalid || bus.m1_rvalid) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", {62'd0, bus.m1_rvalid, bus.m0_rvalid}, 64'd0);
                end else begin
                    rexp_t r;
                    r = rq.pop_front();
                    chk("rvalid_owner", {62'd0, bus.m1_rvalid, bus.m0_rvalid}, {62'd0, r.who});
                    chk("rdata", 64'(r.who[0] ? bus.m0_rdata : bus.m1_rdata), 64'(r.data));
                end
            end
        end
    end

    initial begin
        rstn = 1'b0;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.m1_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held while both request.
        bus.m0_req = 1'b1; bus.m0_addr = 14'h0020;
        bus.m1_req = 1'b1; bus.m1_addr = 14'h0021;
        #3;
        chk("reset_rvalids", {62'd0, bus.m1_rvalid, bus.m0_rvalid}, 64'd0);
        @(posedge clk);
        #1;
        chk("reset_rvalids_edge", {62'd0, bus.m1_rvalid, bus.m0_rvalid}, 64'd0);
        rstn = 1'b1;
        // First contested grant after reset goes to M0; M1 follows.
        step(1'b1, 1'b0, 14'h0020, 32'h0, 1'b1, 1'b0, 14'h0021, 32'h0, 1'b0, 2'd1);
        step(1'b0, 1'b0, 14'h0000, 32'h0, 1'b1, 1'b0, 14'h0021, 32'h0, 1'b0, 2'd2);

        // Round-robin: both read every cycle, expect M0,M1,M0,M1,M0,M1.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 14'(14'h0100 + (i + 1) / 2), 32'h0,
                 1'b1, 1'b0, 14'(14'h0200 + i / 2), 32'h0,
                 1'b0, (i % 2 == 0) ? 2'd1 : 2'd2);
        end
        idle();

        // Single M0 read of 0x0010.
        step(1'b1, 1'b0, 14'h0010, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 2'd1);
        idle();

        // Write by M1 then read by M0 of the same word on the next cycle.
        step(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b1, 14'h3FFF, 32'h12345678, 1'b0, 2'd2);
        step(1'b1, 1'b0, 14'h3FFF, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 2'd1);
        idle();
        chk("raw_ref_value", 64'(ref_rd(14'h3FFF)), 64'h12345678);

        // Lock bound (MAX_LOCK=4), last=0 at entry: M1 x(1+4), M0, then
        // lock released -> alternation, then relock -> M1 x(1+4), M0.
        begin
            int j0 = 0;
            int j1 = 0;
            for (int k = 0; k < 16; k++) begin
                logic [1:0] eg;
                logic l;
                eg = (k == 5 || k == 7 || k == 9 || k == 15) ? 2'd1 : 2'd2;
                l  = (k < 6) || (k >= 10);
                step(1'b1, 1'b1, 14'(14'h0300 + j0), 32'(32'hA000 + j0),
                     1'b1, 1'b1, 14'(14'h0310 + j1), 32'(32'hB000 + j1), l, eg);
                if (eg == 2'd1) j0++;
                else j1++;
            end
        end
        idle();
        idle();

        // Reset between grant and the data cycle drops the response.
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 14'h0040;
        bus.m1_req = 1'b0; bus.m1_lock = 1'b0;
        gq.push_back('{2'd1, 1'b0, 14'h0040, bus.m0_wdata});
        @(negedge clk);
        #2;
        rstn = 1'b0;
        bus.m0_req = 1'b0;
        #1;
        chk("midreset_rvalid_now", {62'd0, bus.m1_rvalid, bus.m0_rvalid}, 64'd0);
        @(posedge clk);
        #1;
        chk("midreset_rvalid_edge", {62'd0, bus.m1_rvalid, bus.m0_rvalid}, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle();
        idle();
        // last restored to 1: contested grant goes to M0.
        step(1'b1, 1'b0, 14'h0041, 32'h0, 1'b1, 1'b0, 14'h0042, 32'h0, 1'b0, 2'd1);
        step(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 14'h0042, 32'h0, 1'b0, 2'd2);
        idle();
        idle();

        chk("gq_drained", 64'(gq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
